// File: rtl/apb_master_arb.sv
// apb_master_arb: two-requester round-robin APB master driving NSLV slaves.
// Ports:
//   PCLK, PRESET (sync, active-high)
//   req_valid/req_write [1:0], req_addr/req_wdata [63:0] (32 bits per requester)
//   req_ack [1:0] (comb, one-hot)
//   rsp_valid [1:0], rsp_rdata [31:0], rsp_err
//   PSEL [NSLV-1:0], PENABLE, READ_WRITE, PADDR, PWDATA
//   PRDATA, PREADY
// Optional macro APB_TIMEOUT_EN: aborts an ACCESS phase after TIMEOUT waits.
module apb_master_arb #(
    parameter int NSLV    = 2,
    parameter int SEL_LSB = 6,
    parameter int TIMEOUT = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_write,
    input  logic [63:0]     req_addr,
    input  logic [63:0]     req_wdata,
    output logic [1:0]      req_ack,
    output logic [1:0]      rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err,
    output logic [NSLV-1:0] PSEL,
    output logic            PENABLE,
    output logic            READ_WRITE,
    output logic [31:0]     PADDR,
    output logic [31:0]     PWDATA,
    input  logic [31:0]     PRDATA,
    input  logic            PREADY
);

    localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t          state, state_nxt;
    logic            last_grant;
    logic            owner;
    logic [SELW-1:0] sel_idx;
    logic            arb, any, g;
    logic [31:0]     g_addr, g_wdata, g_hi;
    logic            g_write, dec_err, done, tmo;

    always_comb begin
        any = |req_valid;
        arb = (state == IDLE) || (state == ACCESS && PREADY);
        unique case (1'b1)
            (req_valid == 2'b11): g = ~last_grant;
            (req_valid == 2'b10): g = 1'b1;
            default:              g = 1'b0;
        endcase
        g_addr  = g ? req_addr[63:32]  : req_addr[31:0];
        g_wdata = g ? req_wdata[63:32] : req_wdata[31:0];
        g_write = g ? req_write[1]     : req_write[0];
        // Full upper field is compared so out-of-range indices that alias
        // into SELW bits still raise a decode error.
        g_hi    = g_addr >> SEL_LSB;
        dec_err = (g_hi >= 32'(NSLV));
        done    = (state == ACCESS) && PREADY;
    end

`ifdef APB_TIMEOUT_EN
    logic [31:0] cnt;

    // Fires on the wait cycle whose increment would make cnt == TIMEOUT.
    assign tmo = (state == ACCESS) && !PREADY && (cnt == 32'(TIMEOUT - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET)
            cnt <= '0;
        else if (state_nxt == SETUP)
            cnt <= '0;
        else if (state == ACCESS && !PREADY)
            cnt <= cnt + 32'd1;
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (PRESET)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (any)
                    state_nxt = dec_err ? DERR : SETUP;
            end
            SETUP:
                state_nxt = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    if (any)
                        state_nxt = dec_err ? DERR : SETUP;
                    else
                        state_nxt = IDLE;
                end else if (tmo) begin
                    state_nxt = IDLE;
                end
            end
            DERR:
                state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ack = 2'b00;
        if (arb && any)
            req_ack = g ? 2'b10 : 2'b01;
        PENABLE = (state == ACCESS);
        for (int i = 0; i < NSLV; i++)
            PSEL[i] = (state == SETUP || state == ACCESS) &&
                      (sel_idx == SELW'(i));
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR      <= '0;
            PWDATA     <= '0;
            READ_WRITE <= 1'b0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            sel_idx    <= '0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (done) begin
                rsp_valid <= owner ? 2'b10 : 2'b01;
                rsp_rdata <= READ_WRITE ? 32'd0 : PRDATA;
            end else if (state == DERR || tmo) begin
                rsp_valid <= owner ? 2'b10 : 2'b01;
                rsp_err   <= 1'b1;
            end
            if (|req_ack) begin
                PADDR      <= g_addr;
                PWDATA     <= g_wdata;
                READ_WRITE <= g_write;
                last_grant <= g;
                owner      <= g;
                sel_idx    <= g_addr[SEL_LSB +: SELW];
            end
        end
    end

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
- APB master that shares one APB bus between two requesters (round-robin) and sequences SETUP/ACCESS phases to NSLV slaves.
- Decodes the slave select from the address, drives the per-slave select bits, honours slave PREADY wait states, and returns read data and status to the owning requester.
- Sits between on-chip requesters and the APB slaves (64-word memory slaves).

Parameters:
- NSLV, 2, number of APB slaves; SELW = clog2(NSLV), minimum 1.
- SEL_LSB, 6, LSB of the slave-index field: index = PADDR[SEL_LSB +: SELW]; lower bits pass to the slave as its word address.
- TIMEOUT, 16, ACCESS-cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- req_valid  in  2  request valid per requester (bit i = requester i).
- req_write  in  2  1 = write, 0 = read, per requester.
- req_addr  in  64  requester i address = [32i +: 32].
- req_wdata  in  64  requester i write data = [32i +: 32].
- req_ack  out  2  request accepted this cycle; combinational, one-hot.
- rsp_valid  out  2  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  32  read data; valid while any rsp_valid bit is high.
- rsp_err  out  1  error flag; qualified by rsp_valid.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  APB enable.
- READ_WRITE  out  1  1 = write, 0 = read.
- PADDR  out  32  transfer address.
- PWDATA  out  32  write data.
- PRDATA  in  32  read data from the selected slave (slave outputs muxed/ORed externally).
- PREADY  in  1  slave ready.

Behaviour:
- **Reset.** PRESET sampled high at a rising edge forces, from the next cycle:
  - state IDLE;
  - PSEL, PENABLE, READ_WRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err all 0;
  - last_grant = 1, so requester 0 wins first.
- **Reset mid-transfer.** The in-flight transfer is dropped. No rsp_valid is issued for it.
- **States.** IDLE, SETUP, ACCESS, DERR.
- **Arbitration.** Occurs in IDLE, and in ACCESS in the cycle PREADY = 1.
  - One valid requester: it wins.
  - Both valid: the requester not equal to last_grant wins.
  - req_ack[g] = 1 in the arbitration cycle. At that edge the block captures addr, wdata and write into the APB regs and sets last_grant = g.
  - Requesters may change inputs after the ack edge.
- **Decode.**
  - index < NSLV: next state SETUP, PSEL[index] = 1.
  - index >= NSLV: next state DERR; no PSEL bit is asserted.
- **SETUP** (exactly 1 cycle): PSEL one-hot, PENABLE = 0, PADDR/PWDATA/READ_WRITE stable. Next state ACCESS.
- **ACCESS:** PENABLE = 1, all APB outputs held stable.
  - PREADY = 0: stay in ACCESS (wait state).
  - PREADY = 1: transfer completes at this edge:
    - rsp_valid[g] = 1 for the next cycle;
    - rsp_rdata = PRDATA on reads, 0 on writes;
    - rsp_err = 0.
  - Next state after completion:
    - another request won arbitration in this cycle: SETUP, back-to-back (PSEL may change bits, PENABLE drops to 0);
    - no request won: IDLE, with PSEL = 0 and PENABLE = 0.
- **DERR** (1 cycle): rsp_valid[g] = 1 and rsp_err = 1 in the following cycle, rsp_rdata = 0. Next state IDLE.
- **Latency.** Zero wait states: ack edge → SETUP → ACCESS → rsp_valid in the 3rd cycle after ack. Each PREADY-low cycle adds 1.
- **Simultaneous events.** The rsp_valid of a completing transfer may coincide with the SETUP of the next transfer. req_ack is never given outside IDLE or ACCESS&PREADY.
- **Bus rules.** At most one PSEL bit is high. PENABLE is never high without PSEL.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- **Defined:**
  - a counter clears on SETUP entry and increments each ACCESS cycle with PREADY = 0;
  - when the count reaches TIMEOUT the transfer is aborted: PSEL and PENABLE deassert next cycle, rsp_valid[g] = 1, rsp_err = 1, rsp_rdata = 0, state IDLE;
  - PREADY = 1 in the same cycle that the count reaches TIMEOUT is a normal completion (PREADY wins).
- **Undefined:** no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- **Single write.** Reset; req_valid = 01, write, addr 0x0000_0005, wdata 0xDEAD_BEEF, PREADY tied 1 → req_ack = 01. Next cycle: PSEL = 01, PENABLE = 0. Then PENABLE = 1. rsp_valid = 01 on the 3rd cycle with rsp_err = 0.
- **Read with wait states.** Read addr 0x0000_0045 (slave 1); PREADY low for 3 ACCESS cycles, PRDATA = 0x1234_5678 → PSEL = 10. ACCESS lasts 4 cycles, rsp_valid = 01, rsp_rdata = 0x1234_5678.
- **Contention.** Both requesters valid continuously → grants alternate 0,1,0,1. Transfers are back-to-back with no IDLE cycle between them.
- **Decode error.** NSLV = 2, addr 0x0000_0080 (index 2) → no PSEL asserted; rsp_valid with rsp_err = 1 two cycles after ack.
- **Reset mid-transfer.** Assert PRESET during an ACCESS wait → PSEL, PENABLE and rsp_valid are 0 next cycle. The next request is granted to requester 0.
- **Timeout** (APB_TIMEOUT_EN, TIMEOUT = 4). PREADY held 0 → abort after 4 ACCESS cycles; rsp_err = 1, bus idle.
